// File: rtl/dffn_pipe.sv
// Falling-edge shift pipeline with per-stage valid, sync reset/set and enable.
// Define DFFN_PIPE_PARITY_EN to add per-stage parity and the PERR output.
module dffn_pipe #(
  parameter int                 WIDTH   = 8,
  parameter int                 DEPTH   = 4,
  parameter logic [WIDTH-1:0]   SET_VAL = {WIDTH{1'b1}},
  localparam int                CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [CW-1:0]    CNT
`ifdef DFFN_PIPE_PARITY_EN
  ,
  output logic             PERR
`endif
);

  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CW-1:0]    cnt;

  // Count tracks popcount of vld: one in at stage 0, one out at the tail.
  always_ff @(negedge clk) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
      vld <= '0;
      cnt <= '0;
    end else if (!S) begin
      for (int i = 0; i < DEPTH; i++) dat[i] <= SET_VAL;
      vld <= '1;
      cnt <= CW'(DEPTH);
    end else if (E) begin
      dat[0] <= D;
      vld[0] <= DV;
      for (int i = 1; i < DEPTH; i++) begin
        dat[i] <= dat[i-1];
        vld[i] <= vld[i-1];
      end
      cnt <= cnt + CW'(DV) - CW'(vld[DEPTH-1]);
    end
  end

  assign Q   = dat[DEPTH-1];
  assign QV  = vld[DEPTH-1];
  assign CNT = cnt;

`ifdef DFFN_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;

  always_ff @(negedge clk) begin
    if (!R) begin
      par <= '0;
    end else if (!S) begin
      par <= {DEPTH{^SET_VAL}};
    end else if (E) begin
      par[0] <= ^D;
      for (int i = 1; i < DEPTH; i++) par[i] <= par[i-1];
    end
  end

  assign PERR = QV & ((^Q) != par[DEPTH-1]);
`endif

endmodule

// File: tb/tb_dffn_pipe.sv
// Bench for dffn_pipe: vector table, random scoreboard run, DEPTH=1 sequence.
// Build with DFFN_PIPE_PARITY_EN defined to also check PERR.
module tb_dffn_pipe;

  logic       clk;
  logic       R, S, E, DV;
  logic [7:0] D;
  logic [7:0] Q;
  logic       QV;
  logic [2:0] CNT;

  logic       r1, s1, e1, dv1;
  logic [7:0] d1;
  logic [7:0] q1;
  logic       qv1;
  logic [0:0] cnt1;

`ifdef DFFN_PIPE_PARITY_EN
  logic perr, perr1;
`endif

  dffn_pipe #(.WIDTH(8), .DEPTH(4)) u0 (
    .clk(clk), .R(R), .S(S), .E(E), .D(D), .DV(DV),
    .Q(Q), .QV(QV), .CNT(CNT)
`ifdef DFFN_PIPE_PARITY_EN
    , .PERR(perr)
`endif
  );

  dffn_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .R(r1), .S(s1), .E(e1), .D(d1), .DV(dv1),
    .Q(q1), .QV(qv1), .CNT(cnt1)
`ifdef DFFN_PIPE_PARITY_EN
    , .PERR(perr1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic e,
                      input logic [7:0] d, input logic dv);
    @(posedge clk);
    R = r; S = s; E = e; D = d; DV = dv;
    @(negedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic s, input logic e,
                       input logic [7:0] d, input logic dv);
    @(posedge clk);
    r1 = r; s1 = s; e1 = e; d1 = d; dv1 = dv;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, s, e;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    logic [2:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic s, input logic e,
                              input logic [7:0] d, input logic dv,
                              input logic [7:0] q, input logic qv,
                              input logic [2:0] cnt);
    vec_t v;
    v.r = r; v.s = s; v.e = e; v.d = d; v.dv = dv;
    v.q = q; v.qv = qv; v.cnt = cnt;
    return v;
  endfunction

  typedef struct packed {
    logic [7:0] d;
    logic       dv;
  } st_t;

  typedef struct {
    logic [7:0] q;
    logic       qv;
    logic [2:0] cnt;
  } ex_t;

  st_t pipe[$];
  ex_t expq[$];

  initial begin
    n_chk = 0;
    n_fail = 0;
    R = 1'b0; S = 1'b1; E = 1'b0; D = '0; DV = 1'b0;
    r1 = 1'b0; s1 = 1'b1; e1 = 1'b0; d1 = '0; dv1 = 1'b0;

    // fill-up, hold, reset-over-set, set
    tv.push_back(mk(0, 1, 1, 8'h99, 1, 8'h00, 0, 0));
    tv.push_back(mk(1, 1, 1, 8'h11, 1, 8'h00, 0, 1));
    tv.push_back(mk(1, 1, 1, 8'h22, 1, 8'h00, 0, 2));
    tv.push_back(mk(1, 1, 1, 8'h33, 1, 8'h00, 0, 3));
    tv.push_back(mk(1, 1, 1, 8'h44, 1, 8'h11, 1, 4));
    tv.push_back(mk(1, 1, 0, 8'h55, 0, 8'h11, 1, 4));
    tv.push_back(mk(1, 1, 0, 8'h66, 1, 8'h11, 1, 4));
    tv.push_back(mk(1, 1, 0, 8'h77, 0, 8'h11, 1, 4));
    tv.push_back(mk(1, 1, 0, 8'h88, 1, 8'h11, 1, 4));
    tv.push_back(mk(1, 1, 0, 8'h99, 0, 8'h11, 1, 4));
    tv.push_back(mk(0, 0, 1, 8'h12, 1, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 1, 8'h12, 0, 8'hFF, 1, 4));
    // alternating DV
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 1, 1, 8'h01, 1, 8'h00, 0, 1));
    tv.push_back(mk(1, 1, 1, 8'h02, 0, 8'h00, 0, 1));
    tv.push_back(mk(1, 1, 1, 8'h03, 1, 8'h00, 0, 2));
    tv.push_back(mk(1, 1, 1, 8'h04, 0, 8'h01, 1, 2));
    tv.push_back(mk(1, 1, 1, 8'h05, 1, 8'h02, 0, 2));
    tv.push_back(mk(1, 1, 1, 8'h06, 0, 8'h03, 1, 2));
    tv.push_back(mk(1, 1, 1, 8'h07, 1, 8'h04, 0, 2));
    tv.push_back(mk(1, 1, 1, 8'h08, 0, 8'h05, 1, 2));
    // set ignores E, then invalid data still shifts
    tv.push_back(mk(1, 0, 0, 8'h00, 0, 8'hFF, 1, 4));
    tv.push_back(mk(1, 1, 1, 8'h77, 0, 8'hFF, 1, 3));
    tv.push_back(mk(1, 1, 1, 8'h77, 0, 8'hFF, 1, 2));
    tv.push_back(mk(1, 1, 1, 8'h77, 0, 8'hFF, 1, 1));
    tv.push_back(mk(1, 1, 1, 8'h77, 0, 8'h77, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].s, tv[i].e, tv[i].d, tv[i].dv);
      chk($sformatf("vec%0d_q", i), 32'(Q), 32'(tv[i].q));
      chk($sformatf("vec%0d_qv", i), 32'(QV), 32'(tv[i].qv));
      chk($sformatf("vec%0d_cnt", i), 32'(CNT), 32'(tv[i].cnt));
    end

    // reset asserted between edges must not act before the next negedge
    @(posedge clk);
    R = 1'b0; S = 1'b1; E = 1'b0;
    #2;
    chk("sync_rst_q", 32'(Q), 32'h77);
    @(negedge clk);
    #1;
    chk("sync_rst_after", 32'(Q), 32'h00);

    // random run against a queue-based scoreboard
    pipe = {};
    repeat (4) pipe.push_back('0);
    for (int i = 0; i < 300; i++) begin
      logic r, s, e, dv;
      logic [7:0] d;
      int c;
      ex_t x;
      r = ($urandom_range(0, 29) != 0);
      s = ($urandom_range(0, 29) != 0);
      e = ($urandom_range(0, 3) != 0);
      dv = 1'($urandom);
      d = 8'($urandom);
      if (!r) begin
        pipe = {};
        repeat (4) pipe.push_back('0);
      end else if (!s) begin
        pipe = {};
        repeat (4) pipe.push_back({8'hFF, 1'b1});
      end else if (e) begin
        pipe.push_front({d, dv});
        void'(pipe.pop_back());
      end
      c = 0;
      foreach (pipe[k]) c += int'(pipe[k].dv);
      x.q = pipe[3].d;
      x.qv = pipe[3].dv;
      x.cnt = 3'(c);
      expq.push_back(x);
      step(r, s, e, d, dv);
      x = expq.pop_front();
      chk("sb_q", 32'(Q), 32'(x.q));
      chk("sb_qv", 32'(QV), 32'(x.qv));
      chk("sb_cnt", 32'(CNT), 32'(x.cnt));
`ifdef DFFN_PIPE_PARITY_EN
      chk("sb_perr", 32'(perr), 32'h0);
`endif
    end

    // single-stage instance
    step1(0, 1, 1, 8'h99, 1);
    chk("d1_rst_q", 32'(q1), 32'h00);
    chk("d1_rst_cnt", 32'(cnt1), 32'h0);
    step1(1, 1, 1, 8'hA5, 1);
    chk("d1_q", 32'(q1), 32'hA5);
    chk("d1_qv", 32'(qv1), 32'h1);
    chk("d1_cnt", 32'(cnt1), 32'h1);
    step1(1, 1, 1, 8'h3C, 0);
    chk("d1_q2", 32'(q1), 32'h3C);
    chk("d1_qv2", 32'(qv1), 32'h0);
    chk("d1_cnt2", 32'(cnt1), 32'h0);
    step1(1, 1, 0, 8'hFF, 1);
    chk("d1_hold_q", 32'(q1), 32'h3C);
    chk("d1_hold_cnt", 32'(cnt1), 32'h0);
    step1(1, 0, 0, 8'h00, 0);
    chk("d1_set_q", 32'(q1), 32'hFF);
    chk("d1_set_cnt", 32'(cnt1), 32'h1);
    step1(1, 1, 1, 8'hA5, 1);
    chk("d1_full_cnt", 32'(cnt1), 32'h1);
    step1(1, 1, 1, 8'h5A, 0);
    chk("d1_drain_q", 32'(q1), 32'h5A);
    chk("d1_drain_cnt", 32'(cnt1), 32'h0);
`ifdef DFFN_PIPE_PARITY_EN
    chk("d1_perr", 32'(perr1), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
